// File: rtl/issue_pkg.sv
// Shared types and default sizing for the ID/EX issue controller.
package issue_pkg;

    localparam int NREG_DEFAULT   = 32;
    localparam int RW_DEFAULT     = 5;
    localparam int MD_LAT_DEFAULT = 8;

    // Instruction class as decoded in ID; the reserved code issues like an ALU op.
    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_MULDIV = 2'b10,
        CLS_RSVD   = 2'b11
    } instr_class_e;

    // Occupancy states of the shared iterative mul/div unit.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Long-latency classes whose destination must be tracked until writeback.
    function automatic logic is_tracked_class(input instr_class_e cls);
        case (cls)
            CLS_LOAD, CLS_MULDIV: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Sequencer for the single shared mul/div unit: start pulse, busy window and
// a one-cycle done pulse. An accepted start occupies the unit for the start
// cycle plus MD_LAT further cycles, the last of which is DONE.
import issue_pkg::*;

module md_sequencer #(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic idle_o,
    output logic md_start,
    output logic md_busy,
    output logic md_done
);

    localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State and countdown registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: BUSY counts down and hands over to DONE when the
    // count reaches zero, so DONE lands exactly MD_LAT cycles after start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CW'(MD_LAT - 1);
                end else begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode; the start pulse is combinational with the issuing op.
    always_comb begin
        idle_o   = 1'b0;
        md_start = 1'b0;
        md_busy  = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                idle_o   = 1'b1;
                md_start = start_i;
            end
            MD_BUSY: begin
                md_busy = 1'b1;
            end
            MD_DONE: begin
                md_busy = 1'b1;
                md_done = 1'b1;
            end
            default: begin
                idle_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/issue_scoreboard.sv
// ID->EX issue controller: pending-write scoreboard for long-latency
// destinations, RAW/WAW/structural hazard detection, stall/flush generation
// and sequencing of the shared mul/div unit. ALU results are forwarded and
// never tracked; x0 is never tracked.
import issue_pkg::*;

module issue_scoreboard #(
    parameter int NREG   = NREG_DEFAULT,
    parameter int MD_LAT = MD_LAT_DEFAULT,
    parameter int RW     = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic          id_wr_rd,
    input  logic [1:0]    id_class,
    input  logic          ex_redirect,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    output logic          issue,
    output logic          stall_if,
    output logic          stall_id,
    output logic          flush_id,
    output logic          flush_ex,
    output logic          md_start,
    output logic          md_busy,
    output logic          md_done
);

    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] wb_clr_s;
    logic [NREG-1:0] pend_eff_s;
    instr_class_e    cls_s;
    logic            is_md_s;
    logic            raw_s, waw_s, struct_s, hz_s;
    logic            md_idle_s;
    logic            md_req_s;

    // Pending bits register; a reset discards outstanding writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Writeback bypass: a register written back this cycle is already
    // visible in the write-first register file, so it no longer blocks.
    always_comb begin
        wb_clr_s = '0;
        if (wb_valid) begin
            wb_clr_s[wb_rd] = 1'b1;
        end else begin
            wb_clr_s = '0;
        end
        pend_eff_s = pend_q & ~wb_clr_s;
    end

    // Hazard detection against the bypassed scoreboard and unit occupancy.
    always_comb begin
        cls_s    = instr_class_e'(id_class);
        is_md_s  = (cls_s == CLS_MULDIV);
        raw_s    = (id_use_rs1 && (id_rs1 != '0) && pend_eff_s[id_rs1]) ||
                   (id_use_rs2 && (id_rs2 != '0) && pend_eff_s[id_rs2]);
        waw_s    = id_wr_rd && (id_rd != '0) && pend_eff_s[id_rd];
        struct_s = is_md_s && !md_idle_s;
        hz_s     = id_valid && (raw_s || waw_s || struct_s);
    end

    // Pipeline control; a redirect overrides any stall, and the whole
    // control set is held at zero while reset is asserted.
    always_comb begin
        issue    = 1'b0;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (!rst_n) begin
            issue    = 1'b0;
        end else if (ex_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else begin
            stall_if = hz_s;
            stall_id = hz_s;
            flush_ex = hz_s || !id_valid;
            issue    = id_valid && !hz_s;
        end
        md_req_s = issue && is_md_s;
    end

    // Scoreboard update: writeback clears, a new long-latency issue sets,
    // and the set wins when both target the same register.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) begin
            pend_d[wb_rd] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (issue && id_wr_rd && (id_rd != '0) && is_tracked_class(cls_s)) begin
            pend_d[id_rd] = 1'b1;
        end else begin
            pend_d[0] = 1'b0;
        end
        pend_d[0] = 1'b0;
    end

    md_sequencer #(
        .MD_LAT (MD_LAT)
    ) u_md_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_req_s),
        .idle_o   (md_idle_s),
        .md_start (md_start),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard. Expected control vectors are
// written by hand into per-scenario tables, pushed to a queue as each cycle's
// stimulus is driven, and popped and compared at the following negedge.
import issue_pkg::*;

module tb_issue_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_wr_rd;
    logic [1:0] id_class;
    logic       ex_redirect;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       issue, stall_if, stall_id, flush_id, flush_ex;
    logic       md_start, md_busy, md_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    // Observed vector: {issue, stall_if, stall_id, flush_id, flush_ex, md_start, md_busy, md_done}
    logic [7:0] obs;
    assign obs = {issue, stall_if, stall_id, flush_id, flush_ex, md_start, md_busy, md_done};

    localparam logic [7:0] E_ISSUE = 8'b1000_0000;
    localparam logic [7:0] E_BUB   = 8'b0000_1000;
    localparam logic [7:0] E_STALL = 8'b0110_1000;
    localparam logic [7:0] E_REDIR = 8'b0001_1000;
    localparam logic [7:0] E_START = 8'b1000_0100;
    localparam logic [7:0] E_BUSY  = 8'b0000_0010;
    localparam logic [7:0] E_DONE  = 8'b0000_0011;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] cls;
        logic       redir;
        logic       wbv;
        logic [4:0] wbrd;
    } stim_t;

    issue_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_wr_rd    (id_wr_rd),
        .id_class    (id_class),
        .ex_redirect (ex_redirect),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .issue       (issue),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic wr, input logic [1:0] cls, input logic redir,
                                 input logic wbv, input logic [4:0] wbrd);
        stim_t s;
        s.v = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rd = rd;
        s.wr = wr; s.cls = cls; s.redir = redir; s.wbv = wbv; s.wbrd = wbrd;
        return s;
    endfunction

    function automatic stim_t nop(input logic wbv, input logic [4:0] wbrd);
        return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, CLS_ALU, 1'b0, wbv, wbrd);
    endfunction

    task automatic drive(input stim_t s);
        id_valid    = s.v;
        id_rs1      = s.rs1;
        id_use_rs1  = s.u1;
        id_rs2      = s.rs2;
        id_use_rs2  = s.u2;
        id_rd       = s.rd;
        id_wr_rd    = s.wr;
        id_class    = s.cls;
        ex_redirect = s.redir;
        wb_valid    = s.wbv;
        wb_rd       = s.wbrd;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        drive(mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, CLS_MULDIV, 1'b0, 1'b0, 5'd0));
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected %b", obs, e);
        end
        drive(nop(1'b0, 5'd0));
    endtask

    task automatic test_load_use();
        stim_t st[6];
        logic [7:0] ex[6];
        logic [7:0] e;
        st[0] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5,  1'b1, CLS_LOAD, 1'b0, 1'b0, 5'd0); ex[0] = E_ISSUE;
        st[1] = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6,  1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[1] = E_STALL;
        st[2] = st[1];                                                                     ex[2] = E_STALL;
        st[3] = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6,  1'b1, CLS_ALU,  1'b0, 1'b1, 5'd5); ex[3] = E_ISSUE;
        st[4] = nop(1'b0, 5'd0);                                                           ex[4] = E_BUB;
        st[5] = mk(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[5] = E_ISSUE;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_x0();
        stim_t st[3];
        logic [7:0] ex[3];
        logic [7:0] e;
        st[0] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, CLS_LOAD, 1'b0, 1'b0, 5'd0); ex[0] = E_ISSUE;
        st[1] = mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[1] = E_ISSUE;
        st[2] = nop(1'b1, 5'd0);                                                          ex[2] = E_BUB;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL x0_immunity[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_muldiv();
        stim_t st[19];
        logic [7:0] ex[19];
        logic [7:0] e;
        stim_t md2;
        md2 = mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, CLS_MULDIV, 1'b0, 1'b0, 5'd0);
        st[0] = mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, CLS_MULDIV, 1'b0, 1'b0, 5'd0);
        ex[0] = E_START;
        for (int i = 1; i <= 7; i++) begin
            st[i] = md2;
            ex[i] = E_STALL | E_BUSY;
        end
        st[4] = mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, CLS_MULDIV, 1'b1, 1'b0, 5'd0);
        ex[4] = E_REDIR | E_BUSY;
        st[8]  = md2;                                                                        ex[8]  = E_STALL | E_DONE;
        st[9]  = md2;                                                                        ex[9]  = E_START;
        st[10] = mk(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, CLS_ALU, 1'b0, 1'b1, 5'd7);  ex[10] = E_ISSUE | E_BUSY;
        st[11] = mk(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, CLS_ALU, 1'b0, 1'b0, 5'd0);  ex[11] = E_STALL | E_BUSY;
        st[12] = mk(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, CLS_ALU, 1'b0, 1'b1, 5'd8);  ex[12] = E_ISSUE | E_BUSY;
        for (int i = 13; i <= 16; i++) begin
            st[i] = nop(1'b0, 5'd0);
            ex[i] = E_BUB | E_BUSY;
        end
        st[17] = nop(1'b0, 5'd0);                                                            ex[17] = E_BUB | E_DONE;
        st[18] = nop(1'b0, 5'd0);                                                            ex[18] = E_BUB;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL muldiv[t+%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t st[7];
        logic [7:0] ex[7];
        logic [7:0] e;
        st[0] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3,  1'b1, CLS_LOAD, 1'b0, 1'b0, 5'd0); ex[0] = E_ISSUE;
        st[1] = mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd14, 1'b1, CLS_ALU,  1'b1, 1'b0, 5'd0); ex[1] = E_REDIR;
        st[2] = mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd14, 1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[2] = E_STALL;
        st[3] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3,  1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[3] = E_STALL;
        st[4] = mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd14, 1'b1, CLS_ALU,  1'b0, 1'b1, 5'd3); ex[4] = E_ISSUE;
        st[5] = mk(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd14, 1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[5] = E_ISSUE;
        st[6] = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, CLS_ALU,  1'b1, 1'b0, 5'd0); ex[6] = E_REDIR;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL redirect[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_same_cycle();
        stim_t st[7];
        logic [7:0] ex[7];
        logic [7:0] e;
        st[0] = mk(1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd9,  1'b1, CLS_LOAD, 1'b0, 1'b1, 5'd9); ex[0] = E_ISSUE;
        st[1] = mk(1'b1, 5'd9,  1'b1, 5'd0, 1'b0, 5'd15, 1'b1, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[1] = E_STALL;
        st[2] = mk(1'b1, 5'd9,  1'b1, 5'd0, 1'b0, 5'd15, 1'b1, CLS_ALU,  1'b0, 1'b1, 5'd9); ex[2] = E_ISSUE;
        st[3] = nop(1'b1, 5'd12);                                                            ex[3] = E_BUB;
        st[4] = mk(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[4] = E_ISSUE;
        st[5] = mk(1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 5'd16, 1'b1, CLS_RSVD, 1'b0, 1'b0, 5'd0); ex[5] = E_ISSUE;
        st[6] = mk(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, CLS_ALU,  1'b0, 1'b0, 5'd0); ex[6] = E_ISSUE;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL same_cycle[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t st[5];
        logic [7:0] ex[5];
        stim_t st2[10];
        logic [7:0] ex2[10];
        logic [7:0] e;
        st[0] = mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, CLS_MULDIV, 1'b0, 1'b0, 5'd0); ex[0] = E_START;
        for (int i = 1; i < 5; i++) begin
            st[i] = nop(1'b0, 5'd0);
            ex[i] = E_BUB | E_BUSY;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL async_pre[%0d]: got %b expected %b", i, obs, e);
            end
        end
        // Mid-cycle reset with the unit busy (count 4) and an op waiting in ID.
        #1;
        rst_n = 1'b0;
        drive(mk(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, CLS_ALU, 1'b0, 1'b0, 5'd0));
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got %b expected %b", obs, e);
        end
        n_cmp++;
        if (md_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_md_busy: got %b expected 0", md_busy);
        end
        #1;
        rst_n = 1'b1;
        st2[0] = mk(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, CLS_ALU,    1'b0, 1'b0, 5'd0);  ex2[0] = E_ISSUE;
        st2[1] = mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, CLS_MULDIV, 1'b0, 1'b0, 5'd0);  ex2[1] = E_START;
        for (int i = 2; i <= 8; i++) begin
            st2[i] = nop(1'b0, 5'd0);
            ex2[i] = E_BUB | E_BUSY;
        end
        st2[9] = nop(1'b1, 5'd11);                                                              ex2[9] = E_BUB | E_DONE;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(st2[i]);
            exp_q.push_back(ex2[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL async_post[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(nop(1'b0, 5'd0));
        #2;
        test_reset();
        #10;
        rst_n = 1'b1;
        test_load_use();
        test_x0();
        test_muldiv();
        test_redirect();
        test_same_cycle();
        test_async_reset();
        @(posedge clk); #1;
        drive(nop(1'b0, 5'd0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between the decode (ID) and execute (EX) stages of the in-order pipeline.
- Tracks destination registers with outstanding long-latency writes (loads, multi-cycle mul/div) in a per-register pending scoreboard.
- Generates stall/flush controls and sequences the single shared iterative mul/div unit.
- ALU results are fully forwarded, so they are never tracked.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- MD_LAT, 8, mul/div busy cycles (≥2).
- RW, 5, register index width, $clog2(NREG).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- id_valid  in  1  valid instruction in ID.
- id_rs1, id_rs2, id_rd  in  RW  operand and destination indices.
- id_use_rs1, id_use_rs2, id_wr_rd  in  1  operand-used and rd-written flags.
- id_class  in  2  00 ALU, 01 LOAD, 10 MULDIV, 11 reserved (treated as ALU).
- ex_redirect  in  1  taken branch/jump resolved in EX.
- wb_valid  in  1  long-latency writeback this cycle.
- wb_rd  in  RW  writeback destination.
- issue  out  1  ID instruction advances to EX this cycle.
- stall_if, stall_id  out  1  hold PC and IF/ID register.
- flush_id  out  1  clear IF/ID register.
- flush_ex  out  1  load bubble into ID/EX register.
- md_start  out  1  one-cycle start pulse to mul/div unit.
- md_busy  out  1  mul/div unit occupied.
- md_done  out  1  one-cycle result-ready pulse.

Behaviour:
- Reset (async, rst_n=0):
  - pending[] all 0, FSM IDLE, counter 0.
  - All outputs 0.
- wb bypass: bit r reads as pending when pending[r] && !(wb_valid && wb_rd==r).
  - A register cleared in a cycle does not stall in that same cycle (register file is write-first).
- Hazards (combinational, from registered state):
  - raw: id_use_rs1 && rs1!=0 && bypassed pending[rs1]; same check for rs2.
  - waw: id_wr_rd && rd!=0 && bypassed pending[rd].
  - struct: id_class==MULDIV && FSM != IDLE.
  - hz = id_valid && (raw || waw || struct).
- Redirect has priority over stall:
  - ex_redirect=1: flush_id=1, flush_ex=1, issue=0, stall_*=0.
- Otherwise:
  - stall_if = stall_id = hz.
  - flush_ex = hz || !id_valid.
  - issue = id_valid && !hz.
- Scoreboard update at posedge:
  - Clear pending[wb_rd] on wb_valid.
  - Set pending[id_rd] when issue && id_wr_rd && rd!=0 && class ∈ {LOAD, MULDIV}.
  - Set wins over clear for the same register in the same cycle.
  - wb_valid with wb_rd non-pending, or wb_rd==0: no effect.
- Mul/div FSM:
  - IDLE: issue of MULDIV → md_start=1 (combinational, same cycle), next BUSY, cnt=MD_LAT-1.
  - BUSY: md_busy=1, cnt decrements; at cnt==0 → DONE.
  - DONE: md_done=1, md_busy=1 → IDLE.
  - Total occupancy: start cycle + MD_LAT cycles; the next MULDIV may issue the cycle after DONE.
  - ex_redirect does not abort BUSY/DONE, since the in-flight op is older than the branch.
- Reset mid-operation: immediate return to the reset state; the pending write is lost by design because the pipeline is flushed.
- Outputs depend on ID inputs combinationally; no ID→issue register latency.

Decomposition:
- Package issue_pkg:
  - instr_class_e (ALU, LOAD, MULDIV, RSVD).
  - md_state_e (IDLE, BUSY, DONE).
  - Default NREG, RW and MD_LAT constants.
- Sub-module md_sequencer: FSM, counter, md_start/md_busy/md_done.
- Scoreboard array and hazard logic stay in issue_scoreboard.

Test Plan:
- Load-use: LOAD rd=5 issues; next cycle ALU rs1=5 → stall_id=1, flush_ex=1 until wb_valid wb_rd=5; issue=1 in the wb cycle (bypass).
- x0 immunity: LOAD rd=0, then use rs1=0 → no stall, pending unchanged.
- Mul/div structural: MULDIV rd=7 at cycle t → md_start at t, md_done at t+MD_LAT (t+8); second MULDIV stalls until t+9 and issues at t+9.
- Redirect during stall: raw hazard on rs2=3 plus ex_redirect=1 → flush_id=1, flush_ex=1, issue=0, stall_if=0; pending[3] unchanged.
- Same-cycle set/clear: wb_valid wb_rd=9 while LOAD rd=9 issues → pending[9]=1 next cycle.
- Async reset with FSM in BUSY (cnt=4) → md_busy=0, all pending 0 immediately, without waiting for a clock edge.
